// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and elaboration helpers for the chunked sequential adder.
package seq_chunk_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int nchunk(input int width, input int chunk);
      return (chunk > 0) ? width / chunk : 1;
   endfunction

   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_chunk_adder_rca.sv
// Combinational N-bit ripple-carry adder; also exposes the carry into bit N-1
// so the caller can derive signed overflow.
module rca_chunk #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         cout,
   output logic         c_msb
);

   logic c;

   always_comb begin
      c     = cin;
      s     = '0;
      c_msb = cin;
      for (int i = 0; i < N; i++) begin
         if (i == N - 1) c_msb = c;
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: CHUNK bits per clock behind valid/ready handshakes.
// Optional subtract mode is enabled by defining SEQ_CHUNK_ADDER_SUB_EN.
module seq_chunk_adder
   import seq_chunk_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int NCHUNK = nchunk(WIDTH, CHUNK);
   localparam int CW     = cnt_width(NCHUNK);
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
   end

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
   logic             cout_q, cout_d, ovf_q, ovf_d;

   logic [CHUNK-1:0] sum_c;
   logic             co, cm;
   logic [WIDTH-1:0] s_shift;
   logic [WIDTH-1:0] b_in;
   logic             c_in;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
   // Subtraction is a + ~b + 1; the caller's cin is ignored in that mode.
   assign b_in = sub ? ~b : b;
   assign c_in = sub ? 1'b1 : cin;
`else
   assign b_in = b;
   assign c_in = cin;
`endif

   rca_chunk #(.N(CHUNK)) u_rca (
      .a     (a_q[CHUNK-1:0]),
      .b     (b_q[CHUNK-1:0]),
      .cin   (carry_q),
      .s     (sum_c),
      .cout  (co),
      .c_msb (cm)
   );

   // Chunk sums enter at the top so that after NCHUNK steps the LSB chunk sits at bit 0.
   if (NCHUNK == 1) begin : g_single
      assign s_shift = sum_c;
   end else begin : g_multi
      assign s_shift = {sum_c, s_q[WIDTH-1:CHUNK]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b_in;
               carry_d = c_in;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            s_d     = s_shift;
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            carry_d = co;
            if (cnt_q == LAST) begin
               cout_d  = co;
               ovf_d   = co ^ cm;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign s         = s_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule
